// File: rtl/wptr_full_prog.sv
// Write-side pointer and status block for the dual-clock FIFO.
// Optional level/almost-full logic is built when WPTR_FULL_PROG_LEVEL_EN is defined.
module wptr_full_prog #(
   parameter int ADDR_W       = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int AFULL_THRESH = 12
) (
   input  logic              clk_wr,
   input  logic              rst_wr,
   input  logic              wr_en,
   input  logic              wr_ovf_clr,
   input  logic [ADDR_W:0]   rd_gray_async,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W:0]   wr_gray,
   output logic              wr_full,
   output logic              wr_almost_full,
   output logic [ADDR_W:0]   wr_level,
   output logic              wr_ack,
   output logic              wr_overflow
);

   if ((ADDR_W < 32'sd2) || (SYNC_STAGES < 32'sd2) || (AFULL_THRESH < 32'sd1) ||
       (AFULL_THRESH > (32'sd1 << ADDR_W))) begin : g_bad_cfg
      $error("wptr_full_prog: illegal parameter combination");
   end

   logic [ADDR_W:0] bin_r;
   logic [ADDR_W:0] bin_next_s;
   logic [ADDR_W:0] gray_next_s;
   logic [ADDR_W:0] full_cmp_s;
   logic [ADDR_W:0] rd_gray_s;
   logic [ADDR_W:0] sync_r [SYNC_STAGES];
   logic            accept_s;

   assign wr_addr   = bin_r[ADDR_W-1:0];
   assign rd_gray_s = sync_r[SYNC_STAGES-1];

   // Next pointer values and the "full after this edge" Gray pattern.
   always_comb begin
      accept_s    = wr_en & ~wr_full;
      bin_next_s  = bin_r + {{ADDR_W{1'b0}}, accept_s};
      gray_next_s = bin_next_s ^ (bin_next_s >> 1);
      full_cmp_s  = {~gray_next_s[ADDR_W], ~gray_next_s[ADDR_W-1], gray_next_s[ADDR_W-2:0]};
   end

   // Read-pointer synchroniser chain into clk_wr.
   always_ff @(posedge clk_wr or posedge rst_wr) begin
      if (rst_wr) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= '0;
         end
      end else begin
         sync_r[0] <= rd_gray_async;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   // Pointer, full, ack and sticky overflow (set wins over clear).
   always_ff @(posedge clk_wr or posedge rst_wr) begin
      if (rst_wr) begin
         bin_r       <= '0;
         wr_gray     <= '0;
         wr_full     <= 1'b0;
         wr_ack      <= 1'b0;
         wr_overflow <= 1'b0;
      end else begin
         bin_r   <= bin_next_s;
         wr_gray <= gray_next_s;
         wr_full <= (rd_gray_s == full_cmp_s);
         wr_ack  <= accept_s;
         if (wr_en & wr_full) begin
            wr_overflow <= 1'b1;
         end else if (wr_ovf_clr) begin
            wr_overflow <= 1'b0;
         end else begin
            wr_overflow <= wr_overflow;
         end
      end
   end

`ifdef WPTR_FULL_PROG_LEVEL_EN
   localparam logic [ADDR_W:0] THRESH = AFULL_THRESH[ADDR_W:0];

   function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
      logic [ADDR_W:0] b;
      b[ADDR_W] = g[ADDR_W];
      for (int i = ADDR_W - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [ADDR_W:0] rd_bin_s;
   logic [ADDR_W:0] diff_s;

   // Conservative occupancy against the lagging synchronised read pointer.
   always_comb begin
      rd_bin_s = gray2bin(rd_gray_s);
      diff_s   = bin_next_s - rd_bin_s;
   end

   // Registered level and almost-full.
   always_ff @(posedge clk_wr or posedge rst_wr) begin
      if (rst_wr) begin
         wr_level       <= '0;
         wr_almost_full <= 1'b0;
      end else begin
         wr_level       <= diff_s;
         wr_almost_full <= (diff_s >= THRESH);
      end
   end
`else
   assign wr_level       = '0;
   assign wr_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_prog.sv
// Self-checking bench for wptr_full_prog (ADDR_W=4, SYNC_STAGES=2, AFULL_THRESH=12).
module tb_wptr_full_prog;
   logic       clk_wr = 1'b0;
   logic       rst_wr;
   logic       wr_en;
   logic       wr_ovf_clr;
   logic [4:0] rd_gray_async;
   logic [3:0] wr_addr;
   logic [4:0] wr_gray;
   logic       wr_full;
   logic       wr_almost_full;
   logic [4:0] wr_level;
   logic       wr_ack;
   logic       wr_overflow;

   wptr_full_prog #(.ADDR_W(4), .SYNC_STAGES(2), .AFULL_THRESH(12)) dut (
      .clk_wr(clk_wr), .rst_wr(rst_wr), .wr_en(wr_en), .wr_ovf_clr(wr_ovf_clr),
      .rd_gray_async(rd_gray_async), .wr_addr(wr_addr), .wr_gray(wr_gray),
      .wr_full(wr_full), .wr_almost_full(wr_almost_full), .wr_level(wr_level),
      .wr_ack(wr_ack), .wr_overflow(wr_overflow)
   );

   always #5 clk_wr = ~clk_wr;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model in entry counts: total writes, total reads, reads seen
   // by the write side at the last two edges, and the expected flags.
   int m_wr, m_rd, seen0, seen1, m_lvl;
   bit m_full, m_ack, m_ovf;

   typedef struct {
      bit we; bit clr; int rd;
      bit e_full; bit e_ack; bit e_ovf; int e_lvl; bit e_af; int e_addr;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [4:0] gray_of(input int cnt);
      logic [4:0] b;
      b = cnt[4:0];
      return b ^ (b >> 1);
   endfunction

   function automatic int exp_lvl(input int v);
`ifdef WPTR_FULL_PROG_LEVEL_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   function automatic bit exp_af(input int v);
`ifdef WPTR_FULL_PROG_LEVEL_EN
      return (v >= 12);
`else
      return (v < 0);
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wr = 0; m_rd = 0; seen0 = 0; seen1 = 0; m_lvl = 0;
      m_full = 1'b0; m_ack = 1'b0; m_ovf = 1'b0;
   endtask

   // One clock: drive inputs, advance the model, return at the next falling edge.
   task automatic step(input bit we, input bit clr);
      int  used;
      bit  acc;
      wr_en = we; wr_ovf_clr = clr; rd_gray_async = gray_of(m_rd);
      used  = seen1;
      acc   = we && !m_full;
      m_ovf = (we && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_wr  = m_wr + int'(acc);
      m_lvl = m_wr - used;
      m_full = (m_lvl == 16);
      m_ack = acc;
      seen1 = seen0; seen0 = m_rd;
      @(posedge clk_wr);
      @(negedge clk_wr);
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".addr"}, 32'(wr_addr), 32'(m_wr % 16));
      chk({tag, ".gray"}, 32'(wr_gray), 32'(gray_of(m_wr)));
      chk({tag, ".full"}, 32'(wr_full), 32'(m_full));
      chk({tag, ".level"}, 32'(wr_level), 32'(exp_lvl(m_lvl)));
      chk({tag, ".afull"}, 32'(wr_almost_full), 32'(exp_af(m_lvl)));
      chk({tag, ".ack"}, 32'(wr_ack), 32'(m_ack));
      chk({tag, ".ovf"}, 32'(wr_overflow), 32'(m_ovf));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".addr"}, 32'(wr_addr), 32'd0);
      chk({tag, ".gray"}, 32'(wr_gray), 32'd0);
      chk({tag, ".full"}, 32'(wr_full), 32'd0);
      chk({tag, ".level"}, 32'(wr_level), 32'd0);
      chk({tag, ".afull"}, 32'(wr_almost_full), 32'd0);
      chk({tag, ".ack"}, 32'(wr_ack), 32'd0);
      chk({tag, ".ovf"}, 32'(wr_overflow), 32'd0);
   endtask

   task automatic do_reset();
      rst_wr = 1'b1; wr_en = 1'b0; wr_ovf_clr = 1'b0; rd_gray_async = 5'd0;
      model_reset();
      @(negedge clk_wr);
      @(negedge clk_wr);
      rst_wr = 1'b0;
   endtask

   initial begin
      int acks;
      int accepted;
      int guard;
      logic [4:0] prev_gray;

      rst_wr = 1'b1; wr_en = 1'b0; wr_ovf_clr = 1'b0; rd_gray_async = 5'd0;
      model_reset();
      #12;
      check_zero("reset");
      @(negedge clk_wr);
      rst_wr = 1'b0;

      // 16 back-to-back writes into an empty FIFO.
      acks = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0);
         check_model("fill");
         acks += int'(wr_ack);
      end
      chk("fill.full", 32'(wr_full), 32'd1);
      chk("fill.addr", 32'(wr_addr), 32'd0);
      chk("fill.gray", 32'(wr_gray), 32'b11000);
      chk("fill.level", 32'(wr_level), 32'(exp_lvl(16)));
      chk("fill.acks", 32'(acks), 32'd16);

      // Overflow behaviour from full, then read pointer moved to 4.
      tbl.push_back('{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 16, 1'b1, 0});
      tbl.push_back('{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 16, 1'b1, 0});
      tbl.push_back('{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 16, 1'b1, 0});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 16, 1'b1, 0});
      tbl.push_back('{1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 16, 1'b1, 0});
      tbl.push_back('{1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 16, 1'b1, 0});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 16, 1'b1, 0});
      tbl.push_back('{1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 16, 1'b1, 0});
      tbl.push_back('{1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 16, 1'b1, 0});
      tbl.push_back('{1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 16, 1'b1, 0});
      tbl.push_back('{1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 12, 1'b1, 0});
      tbl.push_back('{1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 13, 1'b1, 1});
      foreach (tbl[k]) begin
         m_rd = tbl[k].rd;
         step(tbl[k].we, tbl[k].clr);
         chk($sformatf("tbl%0d.full", k), 32'(wr_full), 32'(tbl[k].e_full));
         chk($sformatf("tbl%0d.ack", k), 32'(wr_ack), 32'(tbl[k].e_ack));
         chk($sformatf("tbl%0d.ovf", k), 32'(wr_overflow), 32'(tbl[k].e_ovf));
         chk($sformatf("tbl%0d.level", k), 32'(wr_level), 32'(exp_lvl(tbl[k].e_lvl)));
         chk($sformatf("tbl%0d.afull", k), 32'(wr_almost_full), 32'(exp_af(tbl[k].e_lvl)));
         chk($sformatf("tbl%0d.addr", k), 32'(wr_addr), 32'(tbl[k].e_addr));
      end

      // Almost-full threshold crossing.
      do_reset();
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
      chk("af11.level", 32'(wr_level), 32'(exp_lvl(11)));
      chk("af11.afull", 32'(wr_almost_full), 32'(exp_af(11)));
      step(1'b1, 1'b0);
      chk("af12.level", 32'(wr_level), 32'(exp_lvl(12)));
      chk("af12.afull", 32'(wr_almost_full), 32'(exp_af(12)));

      // Random writes with a reader trailing three entries behind.
      do_reset();
      accepted = 0; guard = 0; prev_gray = wr_gray;
      while (accepted < 100 && guard < 1000) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
         guard++;
         accepted += int'(wr_ack);
         check_model("rnd");
         chk("rnd.nofull", 32'(wr_full), 32'd0);
         chk("rnd.hamming", 32'($countones(wr_gray ^ prev_gray)), 32'(wr_ack));
`ifdef WPTR_FULL_PROG_LEVEL_EN
         chk("rnd.pessimistic", 32'(int'(wr_level) >= (m_wr - m_rd)), 32'd1);
`endif
         prev_gray = wr_gray;
         if (m_wr - 3 > m_rd) m_rd = m_wr - 3;
      end
      chk("rnd.budget", 32'(accepted >= 100), 32'd1);

      // Asynchronous reset mid-clock with level 9 and overflow set.
      do_reset();
      for (int i = 0; i < 17; i++) step(1'b1, 1'b0);
      m_rd = 7;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      check_model("pre_rst");
      chk("pre_rst.ovf", 32'(wr_overflow), 32'd1);
      chk("pre_rst.level", 32'(wr_level), 32'(exp_lvl(9)));
      #2 rst_wr = 1'b1;
      #1 check_zero("async_rst");
      model_reset();
      rd_gray_async = 5'd0;
      @(negedge clk_wr);
      rst_wr = 1'b0;
      check_zero("post_rst");
      step(1'b1, 1'b0);
      check_model("resume");
      chk("resume.addr", 32'(wr_addr), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
